// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit:
// FSM states, opcode/funct values, aluop and alucontrol codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14,
        TRAP    = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SB   = 6'b101000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU control decoder: maps aluop and the R-type funct field
// onto the 3-bit control word of the downstream ALU stage.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Fixed add/sub for address and branch math, funct table for R-type
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: byte-serial fetch, decode, execute, memory, writeback.
// Build option ILLEGAL_OP_TRAP_EN: unknown opcodes lock up in TRAP until reset.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int INSTR_BYTES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    state_t     state;
    state_t     next;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
    logic [1:0] fidx;

    assign fidx = state[1:0];

    // State register, cleared to the first fetch state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH1;
        end else begin
            state <= next;
        end
    end

    // Next-state and Moore output decode; reset forces outputs quiet
    always_comb begin
        next     = FETCH1;
        memread  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 4'b0000;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = ALUOP_ADD;
        illegal  = 1'b0;
        case (state)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                if (int'(fidx) < INSTR_BYTES) begin
                    memread       = 1'b1;
                    irwrite[fidx] = 1'b1;
                    alusrcb       = 2'b01;
                    pcwrite       = 1'b1;
                    if (int'(fidx) == INSTR_BYTES - 1) begin
                        next = DECODE;
                    end else begin
                        next = state_t'(state + 4'd1);
                    end
                end
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LB, OP_SB: next = MEMADR;
                    OP_R:         next = RTYPEEX;
                    OP_BEQ:       next = BEQEX;
                    OP_J:         next = JEX;
                    OP_ADDI:      next = ADDIEX;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      next = TRAP;
`else
                    default:      next = FETCH1;
`endif
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                next    = (op == OP_LB) ? LBRD : SBWR;
            end
            LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                next    = LBWR;
            end
            LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                next    = RTYPEWR;
            end
            RTYPEWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                pcsrc   = 2'b01;
            end
            JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                next    = ADDIWR;
            end
            ADDIWR: begin
                regwrite = 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP: begin
                illegal = 1'b1;
                next    = TRAP;
            end
`endif
            default: begin
                next = FETCH1;
            end
        endcase
        if (!reset_n) begin
            memread  = 1'b0;
            memwrite = 1'b0;
            iord     = 1'b0;
            irwrite  = 4'b0000;
            regwrite = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b00;
            pcsrc    = 2'b00;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            aluop    = ALUOP_ADD;
            illegal  = 1'b0;
        end
    end

    assign pcen = pcwrite | (branch & zero);

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-stream bench for multicycle_ctrl with an
// instruction-level reference model and per-cycle output compare.
module tb_multicycle_ctrl;

    localparam int NB = 4;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic [3:0] irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic [2:0] alucontrol;
        logic       illegal;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       memread, memwrite, iord, regwrite, regdst, memtoreg;
    logic       alusrca, pcen, illegal;
    logic [3:0] irwrite;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    int   checks = 0;
    int   failures = 0;
    bit   exp_valid = 1'b1;
    vec_t exp_v;
    vec_t seq[$];
    bit   trap_seq;
    bit   rel = 1'b1;
    bit   load = 1'b0;
    logic [5:0] nop, nfn;
    vec_t snap_v;
    logic snap_pcen;
    vec_t rs_v;
    logic rs_pcen;

    multicycle_ctrl #(.INSTR_BYTES(NB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memread    (memread),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t blank();
        vec_t v;
        v = '0;
        v.alucontrol = 3'b010;
        return v;
    endfunction

    function automatic logic [2:0] rfn(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit legal(input logic [5:0] o);
        return o == 6'b100000 || o == 6'b101000 || o == 6'b000000 ||
               o == 6'b000100 || o == 6'b000010 || o == 6'b001000;
    endfunction

    function automatic vec_t actual();
        vec_t a;
        a = '0;
        a.memread = memread;
        a.memwrite = memwrite;
        a.iord = iord;
        a.irwrite = irwrite;
        a.regwrite = regwrite;
        a.regdst = regdst;
        a.memtoreg = memtoreg;
        a.alusrca = alusrca;
        a.alusrcb = alusrcb;
        a.pcsrc = pcsrc;
        a.alucontrol = alucontrol;
        a.illegal = illegal;
        return a;
    endfunction

    // Expected per-cycle outputs of one whole instruction
    task automatic build(input logic [5:0] o, input logic [5:0] f);
        vec_t v;
        seq.delete();
        trap_seq = 1'b0;
        for (int n = 0; n < NB; n++) begin
            v = blank();
            v.memread = 1'b1;
            v.irwrite = 4'(1 << n);
            v.alusrcb = 2'b01;
            v.pcwrite = 1'b1;
            seq.push_back(v);
        end
        v = blank();
        v.alusrcb = 2'b11;
        seq.push_back(v);
        if (o == 6'b100000 || o == 6'b101000) begin
            v = blank();
            v.alusrca = 1'b1;
            v.alusrcb = 2'b10;
            seq.push_back(v);
            if (o == 6'b100000) begin
                v = blank();
                v.memread = 1'b1;
                v.iord = 1'b1;
                seq.push_back(v);
                v = blank();
                v.regwrite = 1'b1;
                v.memtoreg = 1'b1;
                seq.push_back(v);
            end else begin
                v = blank();
                v.memwrite = 1'b1;
                v.iord = 1'b1;
                seq.push_back(v);
            end
        end else if (o == 6'b000000) begin
            v = blank();
            v.alusrca = 1'b1;
            v.alucontrol = rfn(f);
            seq.push_back(v);
            v = blank();
            v.regwrite = 1'b1;
            v.regdst = 1'b1;
            seq.push_back(v);
        end else if (o == 6'b000100) begin
            v = blank();
            v.alusrca = 1'b1;
            v.alucontrol = 3'b110;
            v.branch = 1'b1;
            v.pcsrc = 2'b01;
            seq.push_back(v);
        end else if (o == 6'b000010) begin
            v = blank();
            v.pcwrite = 1'b1;
            v.pcsrc = 2'b10;
            seq.push_back(v);
        end else if (o == 6'b001000) begin
            v = blank();
            v.alusrca = 1'b1;
            v.alusrcb = 2'b10;
            seq.push_back(v);
            v = blank();
            v.regwrite = 1'b1;
            seq.push_back(v);
        end else begin
`ifdef ILLEGAL_OP_TRAP_EN
            v = blank();
            v.illegal = 1'b1;
            seq.push_back(v);
            trap_seq = 1'b1;
`endif
        end
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (exp_valid) begin
            vec_t a;
            vec_t e;
            logic pe;
            a = actual();
            e = exp_v;
            e.pcwrite = 1'b0;
            e.branch = 1'b0;
            pe = exp_v.pcwrite | (exp_v.branch & zero);
            checks++;
            if (a !== e || pcen !== pe) begin
                failures++;
                $display("FAIL cycle t=%0t outputs got=%h pcen=%b want=%h pcen=%b",
                         $time, a, pcen, e, pe);
            end
        end
    end

    task automatic pin(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, req);
        end
    endtask

    task automatic step(input vec_t v, input int zsel);
        @(posedge clk);
        #1;
        if (rel) begin
            reset_n = 1'b1;
            rel = 1'b0;
        end
        if (load) begin
            op = nop;
            funct = nfn;
            load = 1'b0;
        end
        zero = (zsel == 2) ? 1'($urandom % 2) : zsel[0];
        exp_v = v;
    endtask

    task automatic do_instr(input logic [5:0] o, input logic [5:0] f,
                            input int zsel, input int abort_at,
                            input int pin_at);
        vec_t tv;
        build(o, f);
        for (int i = 0; i < seq.size(); i++) begin
            if (i == 0) begin
                nop = o;
                nfn = f;
                load = 1'b1;
            end
            step(seq[i], zsel);
            if (i == pin_at) begin
                @(negedge clk);
                #1;
                snap_v = actual();
                snap_pcen = pcen;
            end
            if (i == abort_at) begin
                if (i != pin_at) @(negedge clk);
                #2;
                reset_n = 1'b0;
                exp_v = blank();
                #1;
                rs_v = actual();
                rs_pcen = pcen;
                rel = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
        end
        if (trap_seq) begin
            tv = seq[seq.size() - 1];
            repeat (4) step(tv, zsel);
            @(posedge clk);
            #1;
            reset_n = 1'b0;
            exp_v = blank();
            rel = 1'b1;
        end
    endtask

    initial begin
        logic [5:0] o;
        logic [5:0] f;
        int k;
        int ab;
        logic [5:0] fl[6];
        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        exp_v = blank();
        #2;
        pin("reset_alucontrol", int'(alucontrol), 3'b010);
        pin("reset_memread_pcen", int'({memread, pcen}), 0);
        @(posedge clk);
        #1;

        do_instr(6'b000000, 6'b100010, 2, -1, 3);
        pin("rsub_irwrite_f4", int'(snap_v.irwrite), 4'b1000);
        do_instr(6'b000000, 6'b100010, 2, -1, 5);
        pin("rsub_alucontrol", int'(snap_v.alucontrol), 3'b110);
        do_instr(6'b000000, 6'b100000, 2, 5, -1);
        pin("midreset_alucontrol", int'(rs_v.alucontrol), 3'b010);
        pin("midreset_alusrca_pcen", int'({rs_v.alusrca, rs_pcen}), 0);
        do_instr(6'b000100, 6'b000000, 1, -1, 0);
        pin("release_fetch1", int'({snap_v.irwrite, snap_v.memread, snap_pcen}), 6'b000111);
        do_instr(6'b000100, 6'b000000, 1, -1, 4);
        do_instr(6'b000100, 6'b000000, 1, -1, 5);
        pin("beq_taken", int'({snap_pcen, snap_v.pcsrc, snap_v.alucontrol}), 6'b101110);
        do_instr(6'b000100, 6'b000000, 0, -1, 5);
        pin("beq_not_taken_pcen", int'(snap_pcen), 0);
        do_instr(6'b100000, 6'b000000, 2, -1, 6);
        pin("lb_lbrd", int'({snap_v.iord, snap_v.memread}), 2'b11);
        do_instr(6'b101000, 6'b000000, 2, -1, 6);
        pin("sb_sbwr", int'({snap_v.memwrite, snap_v.iord}), 2'b11);
        do_instr(6'b000000, 6'b101010, 2, -1, 5);
        pin("slt_alucontrol", int'(snap_v.alucontrol), 3'b111);
        do_instr(6'b000000, 6'b111111, 2, -1, 5);
        pin("badfunct_alucontrol", int'(snap_v.alucontrol), 3'b010);
        do_instr(6'b000010, 6'b000000, 0, -1, 5);
        pin("j_pcsrc_pcen", int'({snap_v.pcsrc, snap_pcen}), 3'b101);
`ifdef ILLEGAL_OP_TRAP_EN
        do_instr(6'b111111, 6'b000000, 2, -1, 5);
        pin("trap_illegal", int'({snap_v.illegal, snap_v.memread, snap_pcen}), 3'b100);
`else
        do_instr(6'b111111, 6'b000000, 2, -1, 4);
        pin("nop_illegal", int'(snap_v.illegal), 0);
`endif
        do_instr(6'b001000, 6'b000000, 2, -1, 0);
        pin("after_illegal_fetch1", int'({snap_v.irwrite, snap_v.illegal}), 5'b00010);

        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 9);
            f = fl[$urandom_range(0, 5)];
            case (k)
                0: o = 6'b100000;
                1: o = 6'b101000;
                2, 3: o = 6'b000000;
                4, 5: o = 6'b000100;
                6: o = 6'b000010;
                7: o = 6'b001000;
                8: begin
                    o = 6'($urandom);
                    while (legal(o)) o = 6'($urandom);
                end
                default: begin
                    o = 6'b000000;
                    f = 6'($urandom);
                end
            endcase
            ab = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 6) : -1;
            do_instr(o, f, 2, ab, -1);
        end
        step(blank(), 2);
        exp_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
